// File: rtl/boot_pkg.sv
// Shared types and widths for the boot copy controller.
package boot_pkg;
  localparam int BOOT_ROM_AW = 4;
  localparam int BOOT_DW     = 16;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE, ERR} boot_state_t;
endpackage

// File: rtl/boot_copy_ctrl.sv
// Boot sequencer: copies the boot ROM into RAM with a running checksum,
// then releases the CPU and hands it the RAM bus.
module boot_copy_ctrl
  import boot_pkg::*;
#(
  parameter int ROM_WORDS = 16,
  parameter int RAM_AW    = 12,
  parameter int DEST_BASE = 0,
  parameter int TMO_CYC   = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_reboot,
  output logic                   o_rom_cs,
  output logic                   o_rom_we,
  output logic [BOOT_ROM_AW-1:0] o_rom_addr,
  input  logic [BOOT_DW-1:0]     i_rom_dout,
  output logic                   o_ram_cs,
  output logic                   o_ram_we,
  output logic [RAM_AW-1:0]      o_ram_addr,
  output logic [BOOT_DW-1:0]     o_ram_din,
  input  logic                   i_ram_rdy,
  input  logic                   i_cpu_cs,
  input  logic                   i_cpu_we,
  input  logic [RAM_AW-1:0]      i_cpu_addr,
  input  logic [BOOT_DW-1:0]     i_cpu_din,
  output logic                   o_cpu_halt,
  output logic                   o_boot_busy,
  output logic                   o_boot_done,
  output logic                   o_boot_err,
  output logic [BOOT_DW-1:0]     o_boot_sum
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [BOOT_ROM_AW-1:0] LAST_IDX = BOOT_ROM_AW'(ROM_WORDS - 1);
  localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TMO_CYC - 1);

  boot_state_t            r_state, w_next;
  logic [BOOT_ROM_AW-1:0] r_idx;
  logic [BOOT_DW-1:0]     r_sum, r_data;
  logic [TMO_W-1:0]       r_tmo;
  logic                   w_cap, w_adv, w_tmo_inc, w_tmo_clr, w_restart;
  logic [RAM_AW-1:0]      w_dest;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cap     = 1'b0;
    w_adv     = 1'b0;
    w_tmo_inc = 1'b0;
    w_tmo_clr = 1'b0;
    w_restart = 1'b0;
    case (r_state)
      IDLE: w_next = RD;
      RD:   w_next = CAP;
      CAP: begin
        w_cap  = 1'b1;
        w_next = WR;
      end
      WR: begin
        if (i_ram_rdy) begin
          w_tmo_clr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_next = DONE;
          end else begin
            w_adv  = 1'b1;
            w_next = RD;
          end
        end else begin
          // The cycle that brings the count to TMO_CYC is the last WR cycle.
          w_tmo_inc = 1'b1;
          if (r_tmo == TMO_LAST) w_next = ERR;
        end
      end
      DONE, ERR: begin
        if (i_reboot) begin
          w_restart = 1'b1;
          w_next    = RD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_sum  <= '0;
      r_data <= '0;
      r_tmo  <= '0;
    end else if (w_restart) begin
      r_idx <= '0;
      r_sum <= '0;
      r_tmo <= '0;
    end else begin
      if (w_cap) begin
        r_data <= i_rom_dout;
        r_sum  <= r_sum + i_rom_dout;
      end
      if (w_adv) r_idx <= r_idx + 1'b1;
      if (w_tmo_clr)      r_tmo <= '0;
      else if (w_tmo_inc) r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_dest = RAM_AW'(DEST_BASE) + RAM_AW'(r_idx);

  // Bus mux: loader owns ROM/RAM while copying, CPU owns RAM only in DONE.
  always_comb begin
    o_rom_cs   = 1'b0;
    o_rom_addr = '0;
    o_ram_cs   = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    case (r_state)
      RD, CAP: begin
        o_rom_cs   = 1'b1;
        o_rom_addr = r_idx;
      end
      WR: begin
        o_ram_cs   = 1'b1;
        o_ram_we   = 1'b1;
        o_ram_addr = w_dest;
        o_ram_din  = r_data;
      end
      DONE: begin
        o_ram_cs   = i_cpu_cs;
        o_ram_we   = i_cpu_we;
        o_ram_addr = i_cpu_addr;
        o_ram_din  = i_cpu_din;
      end
      default: ;
    endcase
  end

  assign o_rom_we    = 1'b0;
  assign o_cpu_halt  = (r_state != DONE);
  assign o_boot_busy = (r_state == RD) || (r_state == CAP) || (r_state == WR);
  assign o_boot_done = (r_state == DONE);
  assign o_boot_err  = (r_state == ERR);
  assign o_boot_sum  = r_sum;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Directed bench for boot_copy_ctrl: ROM/RAM models, write log, vector tables.
module tb_boot_copy_ctrl;
  import boot_pkg::*;

  localparam int RAM_AW  = 12;
  localparam int TMO_CYC = 255;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_vec_t;

  typedef struct {
    logic        cs, we;
    logic [11:0] addr;
    logic [15:0] din;
    logic        ecs, ewe;
    logic [11:0] eaddr;
    logic [15:0] edin;
  } pt_vec_t;

  logic clk = 0, rst_n = 0, reboot = 0;
  logic rom_cs, rom_we, ram_cs, ram_we, ram_rdy;
  logic [3:0]  rom_addr;
  logic [15:0] rom_q = '0, ram_din, boot_sum;
  logic [11:0] ram_addr;
  logic        cpu_cs = 0, cpu_we = 0;
  logic [11:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic        cpu_halt, boot_busy, boot_done, boot_err;

  always #5 clk = ~clk;

  boot_copy_ctrl #(.ROM_WORDS(16), .RAM_AW(RAM_AW), .DEST_BASE(0), .TMO_CYC(TMO_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_reboot(reboot),
    .o_rom_cs(rom_cs), .o_rom_we(rom_we), .o_rom_addr(rom_addr), .i_rom_dout(rom_q),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
    .i_ram_rdy(ram_rdy),
    .i_cpu_cs(cpu_cs), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
    .o_cpu_halt(cpu_halt), .o_boot_busy(boot_busy), .o_boot_done(boot_done),
    .o_boot_err(boot_err), .o_boot_sum(boot_sum)
  );

  // ROM image and synchronous-read ROM model
  logic [15:0] rom [16];
  always @(posedge clk) if (rom_cs && !rom_we) rom_q <= rom[rom_addr];

  // RAM model: stalls the write to stall_addr for stall_len cycles
  int stall_addr = -1;
  int stall_len  = 0;
  int held = 0;
  assign ram_rdy = !(ram_cs && ram_we && (int'(ram_addr) == stall_addr) && (held < stall_len));

  logic [15:0] mem [4096];
  int  wr_cnt [4096];
  int  stb_cnt [4096];
  int  total_wr = 0;
  bit  clr = 0;
  bit  rom_we_seen = 0;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) begin
        wr_cnt[i]  <= 0;
        stb_cnt[i] <= 0;
      end
      total_wr <= 0;
    end else if (ram_cs && ram_we) begin
      stb_cnt[ram_addr] <= stb_cnt[ram_addr] + 1;
      if (ram_rdy) begin
        mem[ram_addr]    <= ram_din;
        wr_cnt[ram_addr] <= wr_cnt[ram_addr] + 1;
        total_wr         <= total_wr + 1;
      end
    end
    held <= (ram_cs && ram_we && !ram_rdy) ? held + 1 : 0;
    if (rom_we) rom_we_seen <= 1'b1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_sum(input int n);
    logic [15:0] s = '0;
    for (int i = 0; i < n; i++) s = s + rom[i];
    return s;
  endfunction

  // Counts cycles until DONE or ERR; flags any cycle where halt is low before DONE.
  task automatic run_to_end(output int n, output bit halt_bad);
    n = 0;
    halt_bad = 0;
    while (!boot_done && !boot_err && n < 600) begin
      if (!cpu_halt) halt_bad = 1;
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    clr = 1;
    tick();
    tick();
    clr = 0;
    rst_n = 1;
  endtask

  wr_vec_t copy_tbl [16];
  pt_vec_t pt_tbl [4];
  logic [15:0] img [16];

  initial begin
    int  n;
    bit  hb;
    logic [15:0] full_sum;

    img = '{16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3010, 16'h4000, 16'h0007,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 16; i++) begin
      rom[i] = img[i];
      copy_tbl[i] = '{addr: 12'(i), data: img[i]};
    end
    pt_tbl[0] = '{1'b1, 1'b1, 12'h123, 16'hBEEF, 1'b1, 1'b1, 12'h123, 16'hBEEF};
    pt_tbl[1] = '{1'b1, 1'b0, 12'h456, 16'h0000, 1'b1, 1'b0, 12'h456, 16'h0000};
    pt_tbl[2] = '{1'b0, 1'b0, 12'h7FF, 16'h1234, 1'b0, 1'b0, 12'h7FF, 16'h1234};
    pt_tbl[3] = '{1'b1, 1'b1, 12'hFFF, 16'hA5A5, 1'b1, 1'b1, 12'hFFF, 16'hA5A5};
    // 0xF200+0x4000+0xF800+0x1007+0xF400+0x3010+0x4000+0x0007 mod 2^16
    full_sum = 16'h9E1E;

    // ---- reset state and full copy with ram_rdy always high
    clr = 1;
    tick();
    chk("rst_halt", cpu_halt, 1);
    chk("rst_busy_done_err", {boot_busy, boot_done, boot_err}, 0);
    chk("rst_strobes", {rom_cs, rom_we, ram_cs, ram_we}, 0);
    chk("rst_addr_data", {rom_addr, ram_addr, ram_din}, 0);
    chk("rst_sum", boot_sum, 0);
    clr = 0;
    rst_n = 1;
    #1;
    chk("idle_no_busy", {boot_busy, rom_cs}, 0);
    run_to_end(n, hb);
    chk("done_cycle", n, 49);
    chk("halt_before_done", hb, 0);
    chk("done_halt_low", cpu_halt, 0);
    chk("done_sum", boot_sum, full_sum);
    chk("model_sum", model_sum(16), full_sum);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("copy_data_%0d", i), mem[copy_tbl[i].addr], copy_tbl[i].data);
      chk($sformatf("copy_cnt_%0d", i), wr_cnt[copy_tbl[i].addr], 1);
    end
    chk("total_writes", total_wr, 16);
    chk("rom_never_written", rom_we_seen, 0);

    // ---- CPU pass-through in DONE
    for (int i = 0; i < 4; i++) begin
      cpu_cs = pt_tbl[i].cs; cpu_we = pt_tbl[i].we;
      cpu_addr = pt_tbl[i].addr; cpu_din = pt_tbl[i].din;
      #1;
      chk($sformatf("pt_%0d", i), {ram_cs, ram_we, ram_addr, ram_din},
          {pt_tbl[i].ecs, pt_tbl[i].ewe, pt_tbl[i].eaddr, pt_tbl[i].edin});
      tick();
    end
    chk("pt_mem_123", mem[12'h123], 16'hBEEF);
    chk("pt_mem_fff", mem[12'hFFF], 16'hA5A5);
    cpu_cs = 0; cpu_we = 0;

    // ---- reboot from DONE; mid-copy reboot ignored; CPU ignored while halted
    reboot = 1;
    clr = 1;
    tick();
    reboot = 0;
    clr = 0;
    chk("reboot_busy_halt", {boot_busy, cpu_halt, boot_done}, 3'b110);
    chk("reboot_rd", {rom_cs, rom_addr, ram_cs}, {1'b1, 4'h0, 1'b0});
    chk("reboot_sum_clr", boot_sum, 0);
    cpu_cs = 1; cpu_we = 1; cpu_addr = 12'h200; cpu_din = 16'hDEAD;
    n = 1;
    hb = 0;
    while (!boot_done && !boot_err && n < 600) begin
      if (!cpu_halt) hb = 1;
      reboot = (n == 20);
      tick();
      n++;
    end
    reboot = 0;
    chk("reboot_done_cycle", n, 49);
    chk("reboot_sum", boot_sum, full_sum);
    chk("reboot_writes", total_wr, 16);
    chk("cpu_ignored_halted", wr_cnt[12'h200], 0);
    cpu_cs = 0; cpu_we = 0;

    // ---- word 5 stalled 3 cycles
    stall_addr = 5;
    stall_len  = 3;
    do_reset();
    run_to_end(n, hb);
    chk("stall_done_cycle", n, 52);
    chk("stall_strobe_cycles", stb_cnt[5], 4);
    chk("stall_single_write", wr_cnt[5], 1);
    chk("stall_data", mem[5], rom[5]);
    chk("stall_sum", boot_sum, full_sum);
    chk("stall_writes", total_wr, 16);

    // ---- word 3 never accepted -> timeout
    stall_addr = 3;
    stall_len  = 1000000;
    do_reset();
    run_to_end(n, hb);
    chk("tmo_cycle", n, 267);
    chk("tmo_flags", {boot_err, cpu_halt, boot_done, boot_busy}, 4'b1100);
    chk("tmo_strobe_cycles", stb_cnt[3], TMO_CYC);
    chk("tmo_no_write", wr_cnt[3], 0);
    chk("tmo_partial_sum", boot_sum, model_sum(4));
    chk("tmo_writes", total_wr, 3);
    for (int i = 0; i < 10; i++) tick();
    chk("tmo_strobes_idle", {ram_cs, ram_we, rom_cs}, 0);
    chk("tmo_strobe_frozen", stb_cnt[3], TMO_CYC);

    // ---- reboot from ERR with RAM healthy
    stall_addr = -1;
    reboot = 1;
    clr = 1;
    tick();
    reboot = 0;
    clr = 0;
    chk("err_reboot_clr", {boot_err, boot_busy}, 2'b01);
    n = 1;
    while (!boot_done && !boot_err && n < 600) begin
      tick();
      n++;
    end
    chk("err_reboot_cycle", n, 49);
    chk("err_reboot_sum", boot_sum, full_sum);

    // ---- reset during word 9
    do_reset();
    n = 0;
    while (!(ram_cs && ram_addr == 12'd9) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_word9", ram_addr, 9);
    rst_n = 0;
    #1;
    chk("midrst_halt", {cpu_halt, boot_busy, boot_done, boot_err}, 4'b1000);
    chk("midrst_strobes", {rom_cs, ram_cs, ram_we, ram_addr, ram_din}, 0);
    chk("midrst_sum", boot_sum, 0);
    do_reset();
    run_to_end(n, hb);
    chk("midrst_done_cycle", n, 49);
    chk("midrst_word0_once", wr_cnt[0], 1);
    chk("midrst_sum_final", boot_sum, full_sum);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
